// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: interrupt request handshake between the arbiter (master) and the core (slave).
//   irq_valid : request presented to the core
//   irq_id    : granted source index
//   irq_level : granted source priority
//   irq_ack   : core accepts the presented request
interface irq_arbiter_if #(
   parameter int IdWidth   = 3,
   parameter int PrioWidth = 3
);
   logic                 irq_valid;
   logic [IdWidth-1:0]   irq_id;
   logic [PrioWidth-1:0] irq_level;
   logic                 irq_ack;
   modport master (output irq_valid, irq_id, irq_level, input irq_ack);
   modport slave  (input irq_valid, irq_id, irq_level, output irq_ack);
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches interrupt rises into a pending register, arbitrates and hands one source to the core.
//   clk               : system clock
//   reset             : asynchronous active-low reset
//   irq_in_i          : level interrupt_set per source (rising edge latched)
//   irq_enable_i      : per-source enable mask
//   irq_prio_i        : packed priorities, source i at [i*PrioWidth +: PrioWidth]
//   threshold_i       : core priority level; only strictly higher priorities are granted
//   core              : valid/id/level/ack handshake (irq_arbiter_if.master)
//   interrupt_clear_o : one-hot, one-cycle clear pulse to the granted source
//   pending_o         : pending register readback
//   max_latency_o     : worst valid-to-ack latency seen (only with IRQ_ARBITER_LATENCY_EN)
module irq_arbiter #(
   parameter int NumSrc    = 8,
   parameter int PrioWidth = 3,
   parameter int IdWidth   = $clog2(NumSrc)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NumSrc-1:0]           irq_in_i,
   input  logic [NumSrc-1:0]           irq_enable_i,
   input  logic [NumSrc*PrioWidth-1:0] irq_prio_i,
   input  logic [PrioWidth-1:0]        threshold_i,
   irq_arbiter_if.master               core,
   output logic [NumSrc-1:0]           interrupt_clear_o,
   output logic [NumSrc-1:0]           pending_o
`ifdef IRQ_ARBITER_LATENCY_EN
   ,
   output logic [31:0]                 max_latency_o
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_e;
   state_e               state_q, state_d;
   logic [NumSrc-1:0]    pending_q, pending_d, irq_in_q, clear_q, clear_d, ack_clr;
   logic                 valid_q, valid_d, win_found;
   logic [IdWidth-1:0]   id_q, id_d, win_id;
   logic [PrioWidth-1:0] level_q, level_d, win_prio;
   // Strictly-greater compare keeps the lowest index on priority ties.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_prio  = '0;
      for (int i = 0; i < NumSrc; i++)
         if (pending_q[i] && irq_enable_i[i] && irq_prio_i[i*PrioWidth +: PrioWidth] > threshold_i &&
             (!win_found || irq_prio_i[i*PrioWidth +: PrioWidth] > win_prio)) begin
            win_found = 1'b1;
            win_id    = IdWidth'(i);
            win_prio  = irq_prio_i[i*PrioWidth +: PrioWidth];
         end
   end
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      level_d = level_q;
      ack_clr = '0;
      case (state_q)
         IDLE: if (win_found) begin
            valid_d = 1'b1;
            id_d    = win_id;
            level_d = win_prio;
            state_d = REQ;
         end
         REQ: if (core.irq_ack) begin
            ack_clr[id_q] = 1'b1;
            valid_d       = 1'b0;
            state_d       = CLEAR;
         end
         default: state_d = IDLE;
      endcase
      clear_d = ack_clr;
   end
   // A new rise in the ack cycle wins over the clear.
   assign pending_d = (pending_q & ~ack_clr) | (irq_in_i & ~irq_in_q);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         irq_in_q  <= '0;
         clear_q   <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         irq_in_q  <= irq_in_i;
         clear_q   <= clear_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         level_q   <= level_d;
      end
   assign core.irq_valid    = valid_q;
   assign core.irq_id       = id_q;
   assign core.irq_level    = level_q;
   assign interrupt_clear_o = clear_q;
   assign pending_o         = pending_q;
`ifdef IRQ_ARBITER_LATENCY_EN
   // Counter holds the number of cycles irq_valid has been high, so an ack on the Nth edge reads N.
   logic [31:0] cnt_q, max_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt_q <= '0;
         max_q <= '0;
      end else begin
         if (state_q == IDLE && win_found) cnt_q <= 32'd1;
         else if (state_q == REQ) cnt_q <= cnt_q + {31'd0, ~&cnt_q};
         if (state_q == REQ && core.irq_ack && cnt_q > max_q) max_q <= cnt_q;
      end
   assign max_latency_o = max_q;
`endif
endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Interrupt pending/arbitration stage that sits directly downstream of the timer and other interrupt-producing peripherals.
- Latches rising edges of each source's `interrupt_set` into a pending register.
- Selects the highest-priority enabled pending source above the core's current threshold.
- Presents that source to the core with a valid/ack handshake.
- Returns a one-cycle `interrupt_clear` pulse to the granted source.

Parameters:
- NumSrc, 8, number of interrupt sources.
- PrioWidth, 3, width of each source priority.
- IdWidth, $clog2(NumSrc), width of the source index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NumSrc  level `interrupt_set` from each source.
- irq_enable  in  NumSrc  per-source enable mask.
- irq_prio  in  NumSrc*PrioWidth  packed priority; source i occupies bits [i*PrioWidth +: PrioWidth].
- threshold  in  PrioWidth  current core priority level.
- irq_ack  in  1  core accepts the presented interrupt.
- irq_valid  out  1  request to the core.
- irq_id  out  IdWidth  granted source index.
- irq_level  out  PrioWidth  granted source priority.
- interrupt_clear  out  NumSrc  one-hot, one-cycle clear pulse to the sources.
- pending  out  NumSrc  pending register, for CSR readback.

Behaviour:
- Reset (reset=0, async): pending=0, irq_in_q=0, state=IDLE, irq_valid=0, irq_id=0, irq_level=0, interrupt_clear=0.
- Edge detect: irq_in_q registers irq_in every cycle. Rise on source i = irq_in[i] & ~irq_in_q[i], which sets pending[i] on the next edge.
  - A rise while pending[i] is already 1 merges; no counting.
- Candidate set: pending & irq_enable, restricted to prio > threshold (strictly greater).
  - Winner is the maximum prio; ties go to the lowest index.
  - Computed combinationally from registered pending.
- State machine: IDLE, REQ, CLEAR.
  - IDLE: if the candidate set is non-empty, latch winner id/prio into irq_id/irq_level, set irq_valid=1, go to REQ. Latency from the irq_in rise to irq_valid is 2 cycles.
  - REQ: irq_valid, irq_id and irq_level are held stable regardless of new arrivals, enable or threshold changes (no preemption of a presented request).
    - On irq_ack=1: clear pending[irq_id], drive interrupt_clear[irq_id]=1 for the next cycle only, set irq_valid=0, go to CLEAR.
  - CLEAR: one cycle; interrupt_clear is asserted. Go to IDLE. No new grant is issued in this cycle, which gives the source time to drop its level.
- irq_ack outside REQ is ignored.
- If a rise on source i and the ack-clear of pending[i] happen in the same cycle, set wins: pending[i] stays 1.
- A source disabled after being latched stays pending; it is re-arbitrated once re-enabled.
- Reset asserted mid-REQ or mid-CLEAR aborts immediately.
  - All outputs return to reset values; no clear pulse is emitted.
- Priority 0 is never serviced when threshold ≥ 0. That always holds, so priority 0 means "masked".

Optional Feature:
IRQ_ARBITER_LATENCY_EN
- Defined:
  - Adds output `max_latency` (32 bits).
  - Adds a 32-bit saturating counter per request, started when irq_valid rises and stopped on irq_ack.
  - On ack, if count > max_latency, update max_latency.
  - Counter saturates at 32'hFFFF_FFFF.
  - max_latency resets to 0.
- Not defined: the port and logic are absent; the behaviour is otherwise identical.

Test Plan:
- Reset/basic grant: release reset; irq_enable=8'hFF, prio[2]=3, threshold=0; pulse irq_in[2] high and hold → irq_valid=1 two cycles after the rise, irq_id=2, irq_level=3. Ack → interrupt_clear=8'h04 for exactly one cycle, pending[2]=0, irq_valid low for ≥2 cycles.
- Arbitration/tie: prio[1]=5, prio[4]=5, prio[6]=2; raise irq_in[1,4,6] together → grants in order 1, 4, 6 over successive acks.
- Threshold/mask: prio[3]=2, threshold=2 → no irq_valid. Set threshold=1 → grant id 3. Also prio[5]=0 never granted; irq_enable[5]=0 keeps pending[5]=1 without a grant.
- Stability: in REQ with id=6 (prio 2), raise irq_in[0] with prio 7 → irq_id stays 6 until ack; id 0 is granted next after CLEAR.
- Set-vs-clear collision: ack source 2 in the same cycle as a new rise on irq_in[2] → pending[2]=1 afterwards; source 2 is re-granted.
- Async reset mid-REQ: drop reset between edges → irq_valid=0 and pending=0 immediately; no interrupt_clear pulse. With IRQ_ARBITER_LATENCY_EN, acking 5 cycles after valid leaves max_latency=5.
